// File: rtl/input_capture_if.sv
// CPU port-I/O bus to the input-capture peripheral: address/data strobes out,
// registered read data and the interrupt line back.
interface input_capture_if;
  logic [7:0] address;
  logic [7:0] data_in;
  logic       wen;
  logic       ren;
  logic [7:0] data_out;
  logic       cap_interrupt;

  modport master (output address, data_in, wen, ren, input data_out, cap_interrupt);
  modport slave  (input address, data_in, wen, ren, output data_out, cap_interrupt);
endinterface

// File: rtl/input_capture.sv
// Input-capture unit: measures prescaled time between qualifying edges on cap_in.
// Optional CAP_NOISE_FILTER_EN requires 3 stable synchronized samples before an edge counts.
module input_capture #(
  parameter logic [7:0] ADDR_CTRL = 8'h00,
  parameter logic [7:0] ADDR_PS   = 8'h01,
  parameter logic [7:0] ADDR_CAPL = 8'h02,
  parameter logic [7:0] ADDR_CAPH = 8'h03
) (
  input  logic           clk_in,
  input  logic           rst,
  input  logic           cap_in,
  input_capture_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_MEAS = 2'd2} state_t;
  state_t state_q, state_d;

  logic        sync1_q, sync2_q, level_q, level_d, pulse_q, pulse_d;
  logic        stable, rise, fall;
  logic        int_cap_q, int_cap_d, arm_q, arm_d, en_q, en_d, cont_q, cont_d;
  logic        ovf_q, ovf_d, ovr_q, ovr_d;
  logic [1:0]  edge_sel_q, edge_sel_d;
  logic [2:0]  ps_q, ps_d;
  logic [15:0] cap_q, cap_d, counter_q, counter_d, meas_val;
  logic [7:0]  shadow_q, shadow_d, dout_q, dout_d, ctrl_val;
  logic [6:0]  presc_q, presc_d, presc_mask;
  logic        tick, wr_ctrl, wr_ps, sel_ctrl, sel_ps, sel_capl, sel_caph;
  logic        hw_cap, hw_arm_clr, hw_ovf;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= cap_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

`ifdef CAP_NOISE_FILTER_EN
  logic hist0_q, hist1_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      hist0_q <= 1'b0;
      hist1_q <= 1'b0;
    end else begin
      hist0_q <= sync2_q;
      hist1_q <= hist0_q;
    end
  end

  assign stable = (sync2_q == hist0_q) && (hist0_q == hist1_q);
`else
  assign stable = 1'b1;
`endif

  // level_q is the last accepted input level; an edge is a change of it
  always_comb begin
    rise    = stable & sync2_q & ~level_q;
    fall    = stable & ~sync2_q & level_q;
    level_d = stable ? sync2_q : level_q;
    case (edge_sel_q)
      2'b01:   pulse_d = fall;
      2'b10:   pulse_d = rise | fall;
      default: pulse_d = rise;
    endcase
  end

  assign presc_mask = ~(7'h7F << ps_q);
  assign tick       = (presc_q & presc_mask) == presc_mask;
  // Value the period counter holds after this cycle's tick, saturating at 16'hFFFF
  assign meas_val   = (counter_q == 16'hFFFF) ? counter_q : counter_q + {15'd0, tick};

  assign sel_ctrl = (bus.address == ADDR_CTRL);
  assign sel_ps   = (bus.address == ADDR_PS);
  assign sel_capl = (bus.address == ADDR_CAPL);
  assign sel_caph = (bus.address == ADDR_CAPH);
  assign wr_ctrl  = bus.wen & sel_ctrl;
  assign wr_ps    = bus.wen & sel_ps;
  assign ctrl_val = {ovr_q, ovf_q, edge_sel_q, cont_q, en_q, arm_q, int_cap_q};

  always_ff @(posedge clk_in) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    presc_d    = en_q ? presc_q + 7'd1 : presc_q;
    hw_cap     = 1'b0;
    hw_arm_clr = 1'b0;
    hw_ovf     = 1'b0;
    if (!(en_q && arm_q)) begin
      state_d   = ST_IDLE;
      counter_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_WAIT;
          counter_d = '0;
        end
        ST_WAIT: begin
          counter_d = '0;
          if (pulse_q) begin
            presc_d = '0;
            state_d = ST_MEAS;
          end
        end
        ST_MEAS: begin
          counter_d = meas_val;
          hw_ovf    = (meas_val == 16'hFFFF);
          if (pulse_q) begin
            hw_cap    = 1'b1;
            presc_d   = '0;
            counter_d = '0;
            if (!cont_q) begin
              hw_arm_clr = 1'b1;
              state_d    = ST_IDLE;
            end
          end
        end
        default: begin
          state_d   = ST_IDLE;
          counter_d = '0;
        end
      endcase
    end
  end

  // Register file: hardware set/clear events override a simultaneous CPU write
  always_comb begin
    int_cap_d  = int_cap_q;
    arm_d      = arm_q;
    en_d       = en_q;
    cont_d     = cont_q;
    edge_sel_d = edge_sel_q;
    ovf_d      = ovf_q;
    ovr_d      = ovr_q;
    ps_d       = ps_q;
    cap_d      = cap_q;
    shadow_d   = shadow_q;
    dout_d     = dout_q;
    if (wr_ctrl) begin
      int_cap_d  = bus.data_in[0];
      arm_d      = bus.data_in[1];
      en_d       = bus.data_in[2];
      cont_d     = bus.data_in[3];
      edge_sel_d = bus.data_in[5:4];
      if (!bus.data_in[6]) ovf_d = 1'b0;
      if (!bus.data_in[7]) ovr_d = 1'b0;
    end
    if (hw_cap) begin
      int_cap_d = 1'b1;
      cap_d     = meas_val;
      if (int_cap_q) ovr_d = 1'b1;
    end
    if (hw_arm_clr) arm_d = 1'b0;
    if (hw_ovf)     ovf_d = 1'b1;
    if (wr_ps)      ps_d  = bus.data_in[2:0];
    if (bus.ren) begin
      if (sel_ctrl) begin
        dout_d = ctrl_val;
      end else if (sel_ps) begin
        dout_d = {5'd0, ps_q};
      end else if (sel_capl) begin
        dout_d   = cap_q[7:0];
        shadow_d = cap_q[15:8];
      end else if (sel_caph) begin
        dout_d = shadow_q;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      int_cap_q  <= 1'b0;
      arm_q      <= 1'b0;
      en_q       <= 1'b0;
      cont_q     <= 1'b0;
      edge_sel_q <= 2'b00;
      ovf_q      <= 1'b0;
      ovr_q      <= 1'b0;
      ps_q       <= 3'd0;
      cap_q      <= 16'd0;
      shadow_q   <= 8'd0;
      dout_q     <= 8'd0;
      counter_q  <= 16'd0;
      presc_q    <= 7'd0;
    end else begin
      int_cap_q  <= int_cap_d;
      arm_q      <= arm_d;
      en_q       <= en_d;
      cont_q     <= cont_d;
      edge_sel_q <= edge_sel_d;
      ovf_q      <= ovf_d;
      ovr_q      <= ovr_d;
      ps_q       <= ps_d;
      cap_q      <= cap_d;
      shadow_q   <= shadow_d;
      dout_q     <= dout_d;
      counter_q  <= counter_d;
      presc_q    <= presc_d;
    end
  end

  assign bus.data_out      = dout_q;
  assign bus.cap_interrupt = int_cap_q;
endmodule

// File: tb/tb_input_capture.sv
// Bench for input_capture: cycle-level behavioural model from pin-sample history and
// elapsed-cycle arithmetic, checked every cycle, plus literal scenario expectations.
module tb_input_capture;
  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  logic cap_in = 1'b0;

  input_capture_if bus();

  input_capture dut (.clk_in(clk_in), .rst(rst), .cap_in(cap_in), .bus(bus));

  always #5 clk_in = ~clk_in;

`ifdef CAP_NOISE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam int M_IDLE = 0, M_WAIT = 1, M_MEAS = 2;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  int          n;
  logic        hist [0:5];
  logic        m_level, m_pulse;
  int          m_mode, m_start;
  logic        m_int, m_arm, m_en, m_cont, m_ovf, m_ovr;
  logic [1:0]  m_edge;
  logic [2:0]  m_ps;
  logic [15:0] m_cap;
  logic [7:0]  m_shadow, m_dout;

  task automatic model_reset();
    for (int k = 0; k < 6; k++) hist[k] = 1'b0;
    m_level = 0; m_pulse = 0; m_mode = M_IDLE; m_start = 0;
    m_int = 0; m_arm = 0; m_en = 0; m_cont = 0; m_ovf = 0; m_ovr = 0;
    m_edge = 0; m_ps = 0; m_cap = 0; m_shadow = 0; m_dout = 0;
  endtask

  // One clock edge of the reference: pin seen 2 samples late, edge acted on one cycle later.
  task automatic model_step();
    logic        p_old, new_lvl, stab, old_int, cap_ev, arm_clr, ovf_ev;
    logic [15:0] cnt;
    int          el;
    n++;
    for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = cap_in;
    if (rst) begin
      model_reset();
      return;
    end
    p_old   = m_pulse;
    new_lvl = hist[2];
    stab    = FILT ? (hist[2] == hist[3] && hist[3] == hist[4]) : 1'b1;
    m_pulse = 1'b0;
    if (stab && new_lvl != m_level) begin
      case (m_edge)
        2'b01:   m_pulse = !new_lvl;
        2'b10:   m_pulse = 1'b1;
        default: m_pulse = new_lvl;
      endcase
      m_level = new_lvl;
    end
    el  = (n - m_start) >> m_ps;
    cnt = (m_mode != M_MEAS) ? 16'd0 : (el >= 65535) ? 16'hFFFF : 16'(el);
    if (bus.ren) begin
      case (bus.address)
        8'h00: m_dout = {m_ovr, m_ovf, m_edge, m_cont, m_en, m_arm, m_int};
        8'h01: m_dout = {5'd0, m_ps};
        8'h02: begin m_dout = m_cap[7:0]; m_shadow = m_cap[15:8]; end
        8'h03: m_dout = m_shadow;
        default: ;
      endcase
    end
    cap_ev = 0; arm_clr = 0; ovf_ev = 0; old_int = m_int;
    if (!(m_en && m_arm)) m_mode = M_IDLE;
    else if (m_mode == M_IDLE) m_mode = M_WAIT;
    else if (m_mode == M_WAIT) begin
      if (p_old) begin m_mode = M_MEAS; m_start = n; end
    end else begin
      ovf_ev = (cnt == 16'hFFFF);
      if (p_old) begin
        cap_ev = 1;
        if (m_cont) m_start = n;
        else begin arm_clr = 1; m_mode = M_IDLE; end
      end
    end
    if (bus.wen && bus.address == 8'h00) begin
      {m_edge, m_cont, m_en, m_arm, m_int} = bus.data_in[5:0];
      if (!bus.data_in[6]) m_ovf = 0;
      if (!bus.data_in[7]) m_ovr = 0;
    end
    if (bus.wen && bus.address == 8'h01) m_ps = bus.data_in[2:0];
    if (cap_ev) begin m_int = 1; m_cap = cnt; if (old_int) m_ovr = 1; end
    if (arm_clr) m_arm = 0;
    if (ovf_ev)  m_ovf = 1;
  endtask

  always @(negedge clk_in) begin
    if (check_en) begin
      tests++;
      if (bus.data_out !== m_dout) begin
        fails++;
        $display("FAIL data_out cyc=%0d got=%h exp=%h", n, bus.data_out, m_dout);
      end
      tests++;
      if (bus.cap_interrupt !== m_int) begin
        fails++;
        $display("FAIL cap_interrupt cyc=%0d got=%b exp=%b", n, bus.cap_interrupt, m_int);
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  task automatic wait_n(input int k);
    repeat (k) step();
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
    $display("[TB] %s data=%h exp=%h", name, got, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.address = a; bus.data_in = d; bus.wen = 1'b1;
    step();
    bus.wen = 1'b0;
  endtask

  task automatic rd_check(input logic [7:0] a, input logic [7:0] exp, input string name);
    bus.address = a; bus.ren = 1'b1;
    step();
    bus.ren = 1'b0;
    check8(name, bus.data_out, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; cap_in = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // Raise cap_in now, drop it halfway, return after gap cycles (next rise is gap later)
  task automatic edge_gap(input int gap);
    cap_in = 1'b1;
    for (int i = 0; i < gap; i++) begin
      step();
      if (i == gap / 2 - 1) cap_in = 1'b0;
    end
  endtask

  initial begin
    logic       ed, cont;
    int         hold, op;
    bus.address = 0; bus.data_in = 0; bus.wen = 0; bus.ren = 0;
    n = 0;
    model_reset();
    wait_n(3);
    check_en = 1'b1;
    check8("reset data_out", bus.data_out, 8'h00);
    rst = 1'b0;

    // T1: one-shot, rising edges 250 cycles apart at PS=0
    do_reset(); wr(8'h01, 8'h00); wr(8'h00, 8'h06); wait_n(4);
    edge_gap(250); cap_in = 1'b1; wait_n(8); cap_in = 1'b0;
    rd_check(8'h02, 8'hFA, "T1 CAPL");
    rd_check(8'h03, 8'h00, "T1 CAPH");
    rd_check(8'h00, 8'h05, "T1 CTRL");
    check8("T1 irq", {7'd0, bus.cap_interrupt}, 8'h01);

    // T2: continuous, PS=3, 800-cycle square wave, INT never cleared
    do_reset(); wr(8'h01, 8'h03); wr(8'h00, 8'h0E); wait_n(4);
    edge_gap(800); edge_gap(800); cap_in = 1'b1; wait_n(8); cap_in = 1'b0;
    rd_check(8'h02, 8'h64, "T2 CAPL");
    rd_check(8'h01, 8'h03, "T2 PS");
    rd_check(8'h00, 8'h8F, "T2 CTRL");

    // T4+T3: capture 0x1234, read CAPL, saturate, capture 0xFFFF, shadow still 0x12
    do_reset(); wr(8'h01, 8'h00); wr(8'h00, 8'h0E); wait_n(4);
    edge_gap(4660); cap_in = 1'b1; wait_n(8); cap_in = 1'b0;
    rd_check(8'h02, 8'h34, "T4 CAPL");
    wait_n(68000);
    rd_check(8'h00, 8'h4F, "T3 CTRL ovf");
    cap_in = 1'b1; wait_n(8); cap_in = 1'b0;
    rd_check(8'h03, 8'h12, "T4 CAPH shadow");
    rd_check(8'h02, 8'hFF, "T3 CAPL");
    rd_check(8'h03, 8'hFF, "T3 CAPH");
    rd_check(8'h00, 8'hCF, "T3 CTRL");

    // T5: CPU clears INT_CAP in the very cycle of a one-shot capture
    do_reset(); wr(8'h01, 8'h00); wr(8'h00, 8'h06); wait_n(4);
    edge_gap(20); cap_in = 1'b1; step(); step(); step();
    wr(8'h00, 8'h06); wait_n(2); cap_in = 1'b0;
    check8("T5 irq", {7'd0, bus.cap_interrupt}, 8'h01);
    rd_check(8'h00, 8'h05, "T5 CTRL");
    rd_check(8'h02, 8'h14, "T5 CAPL");
    wr(8'h00, 8'h06); wait_n(4); edge_gap(30); wait_n(10);
    rst = 1'b1; step(); step(); rst = 1'b0;
    check8("T5 rst data_out", bus.data_out, 8'h00);
    rd_check(8'h00, 8'h00, "T5 rst CTRL");
    rd_check(8'h01, 8'h00, "T5 rst PS");
    rd_check(8'h02, 8'h00, "T5 rst CAPL");
    rd_check(8'h03, 8'h00, "T5 rst CAPH");

    // T6: two 2-cycle glitches 30 cycles apart
    do_reset(); wr(8'h01, 8'h00); wr(8'h00, 8'h06); wait_n(4);
    cap_in = 1'b1; step(); step(); cap_in = 1'b0; wait_n(28);
    cap_in = 1'b1; step(); step(); cap_in = 1'b0; wait_n(10);
    check8("T6 irq", {7'd0, bus.cap_interrupt}, FILT ? 8'h00 : 8'h01);
    rd_check(8'h02, FILT ? 8'h00 : 8'd30, "T6 CAPL");

    // Randomized rounds against the model
    for (int r = 0; r < 6; r++) begin
      wr(8'h00, 8'h00);
      wr(8'h01, 8'($urandom_range(0, 3)));
      ed = 1'($urandom); cont = 1'($urandom);
      wr(8'h00, {2'b00, 1'($urandom), ed, cont, 3'b110});
      hold = 0;
      for (int i = 0; i < 600; i++) begin
        if (hold == 0) begin cap_in = ~cap_in; hold = $urandom_range(1, 40); end
        else hold--;
        op = $urandom_range(0, 39);
        if (op < 5) begin
          bus.address = 8'($urandom_range(0, 4)); bus.ren = 1'b1;
        end else if (op == 5) begin
          bus.address = 8'h00; bus.data_in = {2'($urandom), 1'b0, ed, cont, 3'b110}; bus.wen = 1'b1;
        end else if (op == 6) begin
          bus.address = 8'($urandom_range(5, 255)); bus.data_in = 8'($urandom); bus.wen = 1'b1;
        end
        step();
        bus.ren = 1'b0; bus.wen = 1'b0;
      end
      $display("[TB] random round %0d done cap=%h ctrl_int=%b", r, m_cap, m_int);
    end

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
